// File: rtl/data_memory_sized.sv
// Word-organised 32-bit data RAM with byte/half/word stores, sign/zero-extended loads,
// a valid/ready request, programmable wait states and a one-cycle response pulse.
module data_memory_sized #(
  parameter int DEPTH       = 64,
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);
  localparam int         IDX_W     = ADDR_W - 2;
  localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [1:0] SZ_BYTE   = 2'b00;
  localparam logic [1:0] SZ_HALF   = 2'b01;
  localparam logic [1:0] SZ_WORD   = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  state_t            state_reg, state_next;
  logic [3:0]        wait_cnt_reg;
  logic              write_reg;
  logic              signed_reg;
  logic [1:0]        size_reg;
  logic [1:0]        lane_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       ram [DEPTH];

  logic              accept;
  logic              req_err;
  logic [IDX_W-1:0]  req_idx;
  logic [3:0]        byte_en;
  logic [31:0]       wr_word;
  logic [31:0]       rd_word;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       load_data;

  assign req_ready = (state_reg == S_IDLE);
  assign rsp_valid = (state_reg == S_RESP);
  assign accept    = req_valid && req_ready;
  assign req_idx   = req_addr[ADDR_W-1:2];

  // Rejected requests never leave IDLE for the RAM path, so RAM cannot be corrupted.
  always_comb begin
    req_err = 1'b0;
    case (req_size)
      SZ_BYTE: req_err = 1'b0;
      SZ_HALF: req_err = req_addr[0];
      SZ_WORD: req_err = |req_addr[1:0];
      default: req_err = 1'b1;
    endcase
    if ({{(32-IDX_W){1'b0}}, req_idx} >= 32'(DEPTH))
      req_err = 1'b1;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          if (req_err)               state_next = S_RESP;
          else if (WAIT_STATES > 0)  state_next = S_WAIT;
          else                       state_next = S_ACCESS;
        end
      end
      S_WAIT:   if (wait_cnt_reg == 4'd0) state_next = S_ACCESS;
      S_ACCESS: state_next = S_RESP;
      S_RESP:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      wait_cnt_reg <= 4'd0;
    end else begin
      state_reg <= state_next;
      if (accept)
        wait_cnt_reg <= WAIT_INIT;
      else if (state_reg == S_WAIT && wait_cnt_reg != 4'd0)
        wait_cnt_reg <= wait_cnt_reg - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      write_reg  <= req_write;
      signed_reg <= req_signed;
      size_reg   <= req_size;
      lane_reg   <= req_addr[1:0];
      idx_reg    <= req_idx;
      wdata_reg  <= req_wdata;
    end
  end

  // Store data is replicated across lanes; byte enables pick the lanes that change.
  always_comb begin
    byte_en = 4'b1111;
    wr_word = wdata_reg;
    case (size_reg)
      SZ_BYTE: begin
        byte_en = 4'b0001 << lane_reg;
        wr_word = {4{wdata_reg[7:0]}};
      end
      SZ_HALF: begin
        byte_en = lane_reg[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{wdata_reg[15:0]}};
      end
      default: begin
        byte_en = 4'b1111;
        wr_word = wdata_reg;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (state_reg == S_ACCESS && write_reg) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b])
          ram[idx_reg][8*b +: 8] <= wr_word[8*b +: 8];
      end
    end
  end

  assign rd_word = ram[idx_reg];
  assign rd_half = lane_reg[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    case (lane_reg)
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
  end

  always_comb begin
    case (size_reg)
      SZ_BYTE: load_data = {{24{signed_reg & rd_byte[7]}}, rd_byte};
      SZ_HALF: load_data = {{16{signed_reg & rd_half[15]}}, rd_half};
      default: load_data = rd_word;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else if (accept && req_err) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b1;
    end else if (state_reg == S_ACCESS) begin
      rsp_rdata <= write_reg ? 32'd0 : load_data;
      rsp_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_memory_sized.sv
// Randomised self-checking bench for data_memory_sized: a byte-array reference model for data,
// plus three instances (WAIT_STATES 1, 0, 3) for handshake timing.
module tb_data_memory_sized;
  localparam int DEPTH  = 48;
  localparam int ADDR_W = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [7:0]  req_addr = 8'h00;
  logic [31:0] req_wdata = 32'h0;

  logic [2:0]  ready_w;
  logic [2:0]  rvalid_w;
  logic [2:0]  err_w;
  logic [31:0] rdata_w [3];

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] mem_m [DEPTH*4];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    data_memory_sized #(
      .DEPTH(DEPTH),
      .ADDR_W(ADDR_W),
      .WAIT_STATES(gi == 0 ? 1 : (gi == 1 ? 0 : 3))
    ) u_dut (
      .clk(clk),
      .rst_n(rst_n),
      .req_valid(req_valid),
      .req_ready(ready_w[gi]),
      .req_write(req_write),
      .req_size(req_size),
      .req_signed(req_signed),
      .req_addr(req_addr),
      .req_wdata(req_wdata),
      .rsp_valid(rvalid_w[gi]),
      .rsp_rdata(rdata_w[gi]),
      .rsp_err(err_w[gi])
    );
  end

  function automatic int ws_of(int i);
    return (i == 0) ? 1 : ((i == 1) ? 0 : 3);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic bit model_err(logic [1:0] sz, int a);
    return (sz == 2'b11) || (sz == 2'b01 && (a % 2) != 0) ||
           (sz == 2'b10 && (a % 4) != 0) || (a / 4 >= DEPTH);
  endfunction

  function automatic logic [31:0] model_load(logic [1:0] sz, bit sg, int a);
    logic [31:0] v;
    if (sz == 2'b00) begin
      v = {24'h0, mem_m[a]};
      if (sg && mem_m[a][7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'b01) begin
      v = {16'h0, mem_m[a+1], mem_m[a]};
      if (sg && mem_m[a+1][7]) v = v | 32'hFFFF_0000;
    end else begin
      v = {mem_m[a+3], mem_m[a+2], mem_m[a+1], mem_m[a]};
    end
    return v;
  endfunction

  function automatic void model_store(logic [1:0] sz, int a, logic [31:0] wd);
    int n;
    n = (sz == 2'b00) ? 1 : ((sz == 2'b01) ? 2 : 4);
    for (int k = 0; k < n; k++) mem_m[a+k] = wd[8*k +: 8];
  endfunction

  logic [31:0] last_rdata;

  // One transaction on instance 0 (WAIT_STATES=1). lat counts clock edges after the accept edge;
  // the accept edge itself moves an erroring request straight into RESP.
  task automatic xact(input string tag, input bit wr, input logic [1:0] sz, input bit sg,
                      input logic [7:0] a, input logic [31:0] wd);
    bit          exp_err;
    logic [31:0] exp_data;
    int          lat;
    exp_err  = model_err(sz, int'(a));
    exp_data = 32'h0;
    if (!exp_err) begin
      if (wr) model_store(sz, int'(a), wd);
      else    exp_data = model_load(sz, sg, int'(a));
    end
    @(negedge clk);
    check({tag, "_ready"}, 32'(ready_w[0]), 32'd1);
    req_write = wr; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!rvalid_w[0] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    last_rdata = rdata_w[0];
    check({tag, "_lat"}, 32'(lat), exp_err ? 32'd0 : 32'd2);
    check({tag, "_err"}, 32'(err_w[0]), 32'(exp_err));
    check({tag, "_data"}, rdata_w[0], exp_data);
    $display("[TB] %s wr=%0d size=%0d sgn=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
             tag, wr, sz, sg, a, wd, rdata_w[0], err_w[0], lat);
  endtask

  initial begin
    int          accepts [3];
    int          lowrun [3];
    int          pulses [3];
    bit          seen;
    bit          wr;
    logic [1:0]  sz;
    logic [7:0]  a;

    #1;
    check("rst_ready", 32'(ready_w[0]), 32'd1);
    check("rst_rvalid", 32'(rvalid_w[0]), 32'd0);
    check("rst_rdata", rdata_w[0], 32'd0);
    check("rst_err", 32'(err_w[0]), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int w = 0; w < DEPTH; w++)
      xact("init_sw", 1'b1, 2'b10, 1'b0, 8'(w * 4), $urandom);

    xact("t1_sw", 1'b1, 2'b10, 1'b0, 8'h10, 32'hDEAD_BEEF);
    xact("t1_lw", 1'b0, 2'b10, 1'b0, 8'h10, 32'h0);
    check("t1_lw_const", last_rdata, 32'hDEAD_BEEF);

    xact("t2_sb", 1'b1, 2'b00, 1'b0, 8'h11, 32'h0000_0080);
    xact("t2_lb", 1'b0, 2'b00, 1'b1, 8'h11, 32'h0);
    check("t2_lb_const", last_rdata, 32'hFFFF_FF80);
    xact("t2_lbu", 1'b0, 2'b00, 1'b0, 8'h11, 32'h0);
    check("t2_lbu_const", last_rdata, 32'h0000_0080);
    xact("t2_lw", 1'b0, 2'b10, 1'b0, 8'h10, 32'h0);
    check("t2_lw_const", last_rdata, 32'hDEAD_80EF);

    xact("t3_sh", 1'b1, 2'b01, 1'b0, 8'h12, 32'h0000_1234);
    xact("t3_lh", 1'b0, 2'b01, 1'b1, 8'h12, 32'h0);
    check("t3_lh_const", last_rdata, 32'h0000_1234);
    xact("t3_lw", 1'b0, 2'b10, 1'b0, 8'h10, 32'h0);
    check("t3_lw_const", last_rdata, 32'h1234_80EF);

    xact("t4_lw_mis", 1'b0, 2'b10, 1'b0, 8'h13, 32'h0);
    xact("t4_sh_mis", 1'b1, 2'b01, 1'b0, 8'h11, 32'hFFFF_FFFF);
    xact("t4_rsvd", 1'b1, 2'b11, 1'b0, 8'h10, 32'hFFFF_FFFF);
    xact("t4_oor", 1'b0, 2'b10, 1'b0, 8'(DEPTH * 4), 32'h0);
    xact("t4_lw_keep", 1'b0, 2'b10, 1'b0, 8'h10, 32'h0);
    check("t4_keep_const", last_rdata, 32'h1234_80EF);

    // Reset during the wait state of a store: the store must be dropped.
    @(negedge clk);
    req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0; req_addr = 8'h20;
    req_wdata = 32'h0000_0055; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("t6_busy", 32'(ready_w[0]), 32'd0);
    rst_n = 1'b0;
    #1;
    check("t6_ready", 32'(ready_w[0]), 32'd1);
    check("t6_rvalid", 32'(rvalid_w[0]), 32'd0);
    check("t6_rdata", rdata_w[0], 32'd0);
    check("t6_err", 32'(err_w[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rvalid_w[0]) seen = 1'b1;
    end
    check("t6_no_rsp", 32'(seen), 32'd0);
    $display("[TB] t6 reset during WAIT of sw 0x55 @20 -> rsp seen=%0d", seen);
    xact("t6_lw_old", 1'b0, 2'b10, 1'b0, 8'h20, 32'h0);

    // Hold req_valid high on all three instances and measure the handshake rhythm.
    repeat (8) @(negedge clk);
    req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 8'h00;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      accepts[i] = 0; lowrun[i] = 0; pulses[i] = 0;
    end
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (ready_w[i]) begin
          if (accepts[i] > 0) begin
            check($sformatf("t5_low_ws%0d", ws_of(i)), 32'(lowrun[i]), 32'(ws_of(i) + 2));
            check($sformatf("t5_pulse_ws%0d", ws_of(i)), 32'(pulses[i]), 32'd1);
          end
          accepts[i]++;
          lowrun[i] = 0;
          pulses[i] = 0;
        end else begin
          lowrun[i]++;
          if (rvalid_w[i]) pulses[i]++;
        end
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t5_accepts_ws%0d", ws_of(i)), 32'(accepts[i]),
            32'((40 + ws_of(i) + 2) / (ws_of(i) + 3)));
      $display("[TB] t5 ws=%0d accepts=%0d in 40 cycles", ws_of(i), accepts[i]);
    end
    repeat (10) @(negedge clk);

    for (int r = 0; r < 200; r++) begin
      wr = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) a = 8'($urandom_range(0, DEPTH * 4 - 1));
      else                           a = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 4) != 0 && sz != 2'b11) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      xact(wr ? "rnd_st" : "rnd_ld", wr, sz, 1'($urandom_range(0, 1)), a, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
